// File: rtl/lvds_rx_pkg.sv
// Shared types and constants for the ADC LVDS receive path.
// Holds the aligner state encoding, the ADC frame pattern and the SLIP_CNT width helper.
package lvds_rx_pkg;

    typedef enum logic [2:0] {
        ST_CHECK,
        ST_SLIP,
        ST_SETTLE,
        ST_LOCK,
        ST_FAIL
    } align_state_t;

    localparam logic [9:0] ADC_FRAME_PATTERN = 10'b1111100000;

    function automatic int slip_cnt_w(input int max_slips);
        return $clog2(max_slips + 1);
    endfunction

endpackage

// File: rtl/lvds_word_align_if.sv
// Word-aligner bus: deserializer word and restart in, bitslip, status and aligned data out.
// master = aligner side, slave = deserializer / sample-logic side.
interface lvds_word_align_if #(
    parameter int WIDTH  = 10,
    parameter int SLIP_W = 5
);
    logic              align_start;
    logic [WIDTH-1:0]  q;
    logic              bitslip;
    logic              locked;
    logic              align_fail;
    logic [SLIP_W-1:0] slip_cnt;
    logic [WIDTH-1:0]  dout;
    logic              dout_valid;

    modport master (
        input  align_start, q,
        output bitslip, locked, align_fail, slip_cnt, dout, dout_valid
    );

    modport slave (
        output align_start, q,
        input  bitslip, locked, align_fail, slip_cnt, dout, dout_valid
    );
endinterface

// File: rtl/lvds_word_align_mon.sv
// Pattern compare plus consecutive-match and consecutive-error counters for the aligner FSM.
// Latency: match/match_done/lock_lost are combinational on the registered word.
// Backpressure: none; counters advance only while the FSM enables them.
module lvds_word_align_mon #(
    parameter int               WIDTH       = 10,
    parameter logic [WIDTH-1:0] PATTERN     = '0,
    parameter int               MATCH_COUNT = 16,
    parameter int               ERR_LIMIT   = 3
) (
    input  logic             clkdiv,
    input  logic             rst,
    input  logic [WIDTH-1:0] q_r,
    input  logic             chk_en,
    input  logic             lock_en,
    input  logic             clr,
    output logic             match,
    output logic             match_done,
    output logic             lock_lost
);
    localparam int MC_W = $clog2(MATCH_COUNT + 1);
    localparam int ER_W = $clog2(ERR_LIMIT + 1);

    logic [MC_W-1:0] match_cnt;
    logic [ER_W-1:0] err_cnt;

    assign match = (q_r == PATTERN);
    // Fire on the match that would bring the count to its limit, so the FSM acts on the same edge.
    assign match_done = chk_en && match && (match_cnt == MC_W'(MATCH_COUNT - 1));
    assign lock_lost  = lock_en && !match && (err_cnt == ER_W'(ERR_LIMIT - 1));

    always_ff @(posedge clkdiv or posedge rst) begin
        if (rst) begin
            match_cnt <= '0;
            err_cnt   <= '0;
        end else if (clr || match_done || lock_lost) begin
            match_cnt <= '0;
            err_cnt   <= '0;
        end else begin
            if (chk_en) match_cnt <= match ? match_cnt + MC_W'(1) : '0;
            if (lock_en) err_cnt <= match ? '0 : err_cnt + ER_W'(1);
        end
    end
endmodule

// File: rtl/lvds_word_align.sv
// Frame-lane word aligner: bitslips the ISERDES until the word equals PATTERN, then supervises lock.
// Latency: dout is q delayed by one CLKDIV cycle; all status outputs are registered.
// Backpressure: none; downstream qualifies dout with dout_valid.
module lvds_word_align
    import lvds_rx_pkg::*;
#(
    parameter int               WIDTH         = 10,
    parameter logic [WIDTH-1:0] PATTERN       = ADC_FRAME_PATTERN,
    parameter int               MATCH_COUNT   = 16,
    parameter int               SETTLE_CYCLES = 3,
    parameter int               MAX_SLIPS     = 20,
    parameter int               ERR_LIMIT     = 3
) (
    input logic                  clkdiv,
    input logic                  rst,
    lvds_word_align_if.master    bus
);
    localparam int SLIP_W = slip_cnt_w(MAX_SLIPS);
    localparam int SET_W  = $clog2(SETTLE_CYCLES + 1);

    align_state_t      state;
    logic [WIDTH-1:0]  q_r;
    logic              q_ok;
    logic              bitslip;
    logic              locked;
    logic              align_fail;
    logic [SLIP_W-1:0] slip_cnt;
    logic [SET_W-1:0]  settle_cnt;
    logic              match;
    logic              match_done;
    logic              lock_lost;

    lvds_word_align_mon #(
        .WIDTH       (WIDTH),
        .PATTERN     (PATTERN),
        .MATCH_COUNT (MATCH_COUNT),
        .ERR_LIMIT   (ERR_LIMIT)
    ) u_mon (
        .clkdiv     (clkdiv),
        .rst        (rst),
        .q_r        (q_r),
        .chk_en     ((state == ST_CHECK) && q_ok),
        .lock_en    (state == ST_LOCK),
        .clr        (bus.align_start),
        .match      (match),
        .match_done (match_done),
        .lock_lost  (lock_lost)
    );

    // q_ok keeps the reset value of q_r from being judged as a real word and triggering a slip.
    always_ff @(posedge clkdiv or posedge rst) begin
        if (rst) begin
            state      <= ST_CHECK;
            q_r        <= '0;
            q_ok       <= 1'b0;
            bitslip    <= 1'b0;
            locked     <= 1'b0;
            align_fail <= 1'b0;
            slip_cnt   <= '0;
            settle_cnt <= '0;
        end else begin
            q_r     <= bus.q;
            q_ok    <= 1'b1;
            bitslip <= 1'b0;
            if (bus.align_start) begin
                state      <= ST_CHECK;
                locked     <= 1'b0;
                align_fail <= 1'b0;
                slip_cnt   <= '0;
                settle_cnt <= '0;
            end else begin
                case (state)
                    ST_CHECK: begin
                        if (q_ok) begin
                            if (match_done) begin
                                state  <= ST_LOCK;
                                locked <= 1'b1;
                            end else if (!match) begin
                                if (slip_cnt == SLIP_W'(MAX_SLIPS)) begin
                                    state      <= ST_FAIL;
                                    align_fail <= 1'b1;
                                end else begin
                                    state    <= ST_SLIP;
                                    bitslip  <= 1'b1;
                                    slip_cnt <= slip_cnt + SLIP_W'(1);
                                end
                            end
                        end
                    end
                    ST_SLIP: begin
                        state      <= ST_SETTLE;
                        settle_cnt <= '0;
                    end
                    ST_SETTLE: begin
                        if (settle_cnt == SET_W'(SETTLE_CYCLES - 1)) state <= ST_CHECK;
                        else settle_cnt <= settle_cnt + SET_W'(1);
                    end
                    ST_LOCK: begin
                        if (lock_lost) begin
                            state    <= ST_CHECK;
                            locked   <= 1'b0;
                            slip_cnt <= '0;
                        end
                    end
                    ST_FAIL: state <= ST_FAIL;
                    default: state <= ST_CHECK;
                endcase
            end
        end
    end

    assign bus.bitslip    = bitslip;
    assign bus.locked     = locked;
    assign bus.align_fail = align_fail;
    assign bus.slip_cnt   = slip_cnt;
    assign bus.dout       = q_r;
    assign bus.dout_valid = locked;
endmodule

// File: tb/tb_lvds_word_align.sv
// Directed bench for lvds_word_align with a bitslip-rotating deserializer model.
// Table of from-reset alignment scenarios plus hand-written lock, restart and reset sequences.
module tb_lvds_word_align;
    import lvds_rx_pkg::*;

    localparam logic [9:0] PAT = ADC_FRAME_PATTERN;

    logic clkdiv = 1'b0;
    logic rst    = 1'b1;
    always #5 clkdiv = ~clkdiv;

    lvds_word_align_if #(.WIDTH(10), .SLIP_W(5)) bus  ();
    lvds_word_align_if #(.WIDTH(10), .SLIP_W(5)) bus1 ();

    int         rot      = 0;
    int         pend     = 0;
    logic       bad_en   = 1'b0;
    logic [9:0] bad_word = '0;
    int         n_checks = 0;
    int         n_fail   = 0;

    function automatic logic [9:0] rotl(input logic [9:0] w, input int n);
        logic [19:0] d;
        d = {w, w} << n;
        return d[19:10];
    endfunction

    assign bus.q            = bad_en ? bad_word : rotl(PAT, rot);
    assign bus1.q           = bus.q;
    assign bus1.align_start = 1'b0;

    lvds_word_align u_dut (.clkdiv(clkdiv), .rst(rst), .bus(bus));
    lvds_word_align #(.MATCH_COUNT(1)) u_dut1 (.clkdiv(clkdiv), .rst(rst), .bus(bus1));

    // Deserializer model: each bitslip pulse rotates the word by one bit, two cycles later.
    always @(posedge clkdiv) begin
        #1;
        if (rst) pend = 0;
        else begin
            if (pend > 0) begin
                pend--;
                if (pend == 0) rot = (rot + 9) % 10;
            end
            if (bus.bitslip) pend = 2;
        end
    end

    typedef struct {
        string      name;
        int         rot;
        logic       bad;
        logic [9:0] word;
        int         exp_pulses;
        logic       exp_lock;
        int         max_cyc;
    } vec_t;

    vec_t vecs[5];

    task automatic check(input string nm, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clkdiv);
        #1;
    endtask

    task automatic restart(input int r, input logic b, input logic [9:0] w);
        rst = 1'b1;
        bus.align_start = 1'b0;
        tick();
        rot      = r;
        bad_en   = b;
        bad_word = w;
        tick();
        rst = 1'b0;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout required finish");
        $fatal(1);
    end

    initial begin
        int pulses, run, max_w, min_sp, last, cyc, drops;
        logic [5:0] bad_pat;

        vecs[0] = '{"aligned",   0, 1'b0, 10'h000,  0, 1'b1,  18};
        vecs[1] = '{"rot7",      7, 1'b0, 10'h000,  7, 1'b1, 300};
        vecs[2] = '{"rot9",      9, 1'b0, 10'h000,  9, 1'b1, 300};
        vecs[3] = '{"unlock155", 0, 1'b1, 10'h155, 20, 1'b0, 300};
        vecs[4] = '{"rot3",      3, 1'b0, 10'h000,  3, 1'b1, 300};

        bus.align_start = 1'b0;
        tick();
        tick();
        check("rst_bitslip",    int'(bus.bitslip),    0);
        check("rst_locked",     int'(bus.locked),     0);
        check("rst_align_fail", int'(bus.align_fail), 0);
        check("rst_slip_cnt",   int'(bus.slip_cnt),   0);
        check("rst_dout",       int'(bus.dout),       0);
        check("rst_dout_valid", int'(bus.dout_valid), 0);

        // MATCH_COUNT=1 instance locks on the first valid matching word.
        restart(0, 1'b0, 10'h000);
        tick();
        check("mc1_not_yet", int'(bus1.locked), 0);
        tick();
        check("mc1_locked", int'(bus1.locked), 1);
        check("mc16_not_yet", int'(bus.locked), 0);

        for (int i = 0; i < 5; i++) begin
            restart(vecs[i].rot, vecs[i].bad, vecs[i].word);
            pulses = 0; run = 0; max_w = 0; min_sp = 1000; last = -1000; cyc = 0;
            while (cyc < vecs[i].max_cyc && !bus.locked && !bus.align_fail) begin
                tick();
                cyc++;
                if (bus.bitslip) begin
                    run++;
                    if (run > max_w) max_w = run;
                    if (run == 1) begin
                        pulses++;
                        if (cyc - last < min_sp) min_sp = cyc - last;
                        last = cyc;
                    end
                end else run = 0;
            end
            check({vecs[i].name, " done_in_budget"}, int'(bus.locked || bus.align_fail), 1);
            check({vecs[i].name, " pulses"}, pulses, vecs[i].exp_pulses);
            check({vecs[i].name, " slip_cnt"}, int'(bus.slip_cnt), vecs[i].exp_pulses);
            check({vecs[i].name, " locked"}, int'(bus.locked), int'(vecs[i].exp_lock));
            check({vecs[i].name, " align_fail"}, int'(bus.align_fail), int'(!vecs[i].exp_lock));
            check({vecs[i].name, " dout_valid"}, int'(bus.dout_valid), int'(vecs[i].exp_lock));
            check({vecs[i].name, " dout"}, int'(bus.dout), int'(vecs[i].bad ? vecs[i].word : PAT));
            check({vecs[i].name, " pulse_width_le1"}, int'(max_w <= 1), 1);
            check({vecs[i].name, " spacing_ge4"}, int'(min_sp >= 4), 1);
            if (!vecs[i].exp_lock) begin
                pulses = 0;
                repeat (100) begin
                    tick();
                    if (bus.bitslip) pulses++;
                end
                check({vecs[i].name, " fail_quiet"}, pulses, 0);
                check({vecs[i].name, " fail_held"}, int'(bus.align_fail), 1);
            end
        end

        // Locked with slip_cnt=3: bad,bad,good twice keeps lock (match clears err_cnt).
        bad_word = ~PAT;
        bad_pat  = 6'b110110;
        drops    = 0;
        for (int k = 0; k < 6; k++) begin
            bad_en = bad_pat[5-k];
            tick();
            if (!bus.locked) drops++;
        end
        bad_en = 1'b0;
        repeat (6) begin
            tick();
            if (!bus.locked) drops++;
        end
        check("supervise_drops", drops, 0);
        check("supervise_slip_cnt", int'(bus.slip_cnt), 3);

        // Three consecutive bad words drop lock on the edge after the third.
        bad_en = 1'b1;
        repeat (3) tick();
        bad_en = 1'b0;
        check("loss_still_locked", int'(bus.locked), 1);
        tick();
        check("loss_locked", int'(bus.locked), 0);
        check("loss_slip_cnt", int'(bus.slip_cnt), 0);
        check("loss_dout_valid", int'(bus.dout_valid), 0);
        pulses = 0; cyc = 0;
        while (cyc < 40 && !bus.locked) begin
            tick();
            cyc++;
            if (bus.bitslip) pulses++;
        end
        check("relock_locked", int'(bus.locked), 1);
        check("relock_pulses", pulses, 0);

        // Skew the lane by 2, catch the first slip, then restart during SETTLE.
        rot = 2;
        cyc = 0;
        while (cyc < 40 && !bus.bitslip) begin
            tick();
            cyc++;
        end
        check("settle_saw_slip", int'(bus.bitslip), 1);
        check("settle_slip_cnt_pre", int'(bus.slip_cnt), 1);
        tick();
        bus.align_start = 1'b1;
        tick();
        bus.align_start = 1'b0;
        check("start_settle_slip_cnt", int'(bus.slip_cnt), 0);
        check("start_settle_bitslip", int'(bus.bitslip), 0);
        check("start_settle_locked", int'(bus.locked), 0);
        check("start_settle_fail", int'(bus.align_fail), 0);
        cyc = 0;
        while (cyc < 300 && !bus.locked) begin
            tick();
            cyc++;
        end
        check("start_settle_relock", int'(bus.locked), 1);
        check("start_settle_slip_cnt_post", int'(bus.slip_cnt), 1);

        // Unlockable word from lock: fail, then restart during FAIL.
        bad_word = 10'h155;
        bad_en   = 1'b1;
        cyc = 0;
        while (cyc < 300 && !bus.align_fail) begin
            tick();
            cyc++;
        end
        check("fail_reached", int'(bus.align_fail), 1);
        check("fail_slip_cnt", int'(bus.slip_cnt), 20);
        check("fail_locked", int'(bus.locked), 0);
        bus.align_start = 1'b1;
        tick();
        bus.align_start = 1'b0;
        check("start_fail_align_fail", int'(bus.align_fail), 0);
        check("start_fail_slip_cnt", int'(bus.slip_cnt), 0);
        check("start_fail_locked", int'(bus.locked), 0);

        // Asynchronous reset in the middle of a bitslip pulse.
        cyc = 0;
        while (cyc < 20 && !bus.bitslip) begin
            tick();
            cyc++;
        end
        check("arst_saw_slip", int'(bus.bitslip), 1);
        rst = 1'b1;
        #1;
        check("arst_bitslip",    int'(bus.bitslip),    0);
        check("arst_locked",     int'(bus.locked),     0);
        check("arst_align_fail", int'(bus.align_fail), 0);
        check("arst_slip_cnt",   int'(bus.slip_cnt),   0);
        check("arst_dout",       int'(bus.dout),       0);
        check("arst_dout_valid", int'(bus.dout_valid), 0);
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
